// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter load controller and its integration wrapper.
package counter_ctrl_pkg;

   localparam int CTRL_WIDTH = 4;
   localparam int CTRL_REP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/counter_4bit_load_up.sv
// 4-bit free-running up-counter with synchronous parallel load.
module counter_4bit_load_up (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] data,
   output logic [3:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (load) count <= data;
      else           count <= count + 4'd1;
   end

endmodule

// File: rtl/counter_load_system.sv
// Controller tied to the 4-bit counter; the counter's reset is active-high, so it is inverted here.
module counter_load_system
   import counter_ctrl_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [3:0]            cfg_preset,
   input  logic [3:0]            cfg_terminal,
   input  logic [CTRL_REP_W-1:0] cfg_repeat,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [CTRL_REP_W-1:0] pass_cnt,
   output logic [3:0]            count
);

   logic       load;
   logic [3:0] data;
   logic       rst_hi;

   assign rst_hi = ~reset;

   counter_load_controller #(.WIDTH(4), .REP_W(CTRL_REP_W)) u_ctrl (
      .clock        (clock),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_preset   (cfg_preset),
      .cfg_terminal (cfg_terminal),
      .cfg_repeat   (cfg_repeat),
      .abort        (abort),
      .count        (count),
      .load         (load),
      .data         (data),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt)
   );

   counter_4bit_load_up u_cnt (
      .clk   (clock),
      .rst   (rst_hi),
      .load  (load),
      .data  (data),
      .count (count)
   );

endmodule

// File: rtl/counter_load_controller.sv
// Sequences preset/run passes of a loadable up-counter and pulses done after the final pass.
module counter_load_controller
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = CTRL_WIDTH,
   parameter int REP_W = CTRL_REP_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_preset,
   input  logic [WIDTH-1:0] cfg_terminal,
   input  logic [REP_W-1:0] cfg_repeat,
   input  logic             abort,
   input  logic [WIDTH-1:0] count,
   output logic             load,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] pass_cnt
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   preset_q, preset_d;
   logic [WIDTH-1:0]   term_q, term_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [REP_W-1:0]   pass_q, pass_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         preset_q <= '0;
         term_q   <= '0;
         rep_q    <= '0;
         pass_q   <= '0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         term_q   <= term_d;
         rep_q    <= rep_d;
         pass_q   <= pass_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      preset_d = preset_q;
      term_d   = term_q;
      rep_d    = rep_q;
      pass_d   = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               preset_d = cfg_preset;
               term_d   = cfg_terminal;
               rep_d    = cfg_repeat;
               pass_d   = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            if (count == term_q) begin
               if (pass_q == rep_q) begin
                  state_d = ST_DONE;
               end else begin
                  pass_d  = pass_q + 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
      endcase
      // abort overrides a same-cycle terminal match, so the pass index must not advance
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         pass_d  = pass_q;
      end
   end

   assign cfg_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign load      = (state_q == ST_LOAD);
   assign done      = (state_q == ST_DONE);
   assign data      = busy ? preset_q : '0;
   assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_counter_load_controller.sv
// Randomized bench: expected waveforms come from the pass-length arithmetic d=(terminal-preset) mod 16.
module tb_counter_load_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_preset, cfg_terminal, cfg_repeat;
   logic       abort;
   logic [3:0] cnt;
   logic       load;
   logic [3:0] data;
   logic       busy, done;
   logic [3:0] pass_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   counter_load_controller #(.WIDTH(4), .REP_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_preset   (cfg_preset),
      .cfg_terminal (cfg_terminal),
      .cfg_repeat   (cfg_repeat),
      .abort        (abort),
      .count        (cnt),
      .load         (load),
      .data         (data),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt)
   );

   // environment: the loadable up-counter the controller drives
   always @(posedge clock or negedge reset) begin
      if (!reset)    cnt <= 4'd0;
      else if (load) cnt <= data;
      else           cnt <= cnt + 4'd1;
   end

   task automatic check_idle(input string name);
      nvec++;
      if ({cfg_ready, busy, done, load, data} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
         nerr++;
         $display("FAIL %s: ready/busy/done/load/data got %b %b %b %b %h want 1 0 0 0 0",
                  name, cfg_ready, busy, done, load, data);
      end
   endtask

   // Applies one config and checks every cycle up to and including the done cycle.
   task automatic run_cfg(input logic [3:0] p, t, r, input bit abort_on_accept,
                          input bit hold, input logic [3:0] np, nt, nr);
      int d, n;
      logic [11:0] exp_v, act_v;
      logic [3:0] epass;
      logic eload;
      d = (int'(t) - int'(p) + 16) % 16;
      n = (int'(r) + 1) * (d + 2);
      @(negedge clock);
      check_idle("idle_before_cfg");
      cfg_valid = 1'b1; cfg_preset = p; cfg_terminal = t; cfg_repeat = r;
      abort = abort_on_accept;
      @(posedge clock); #1;
      abort = 1'b0;
      if (hold) begin
         cfg_preset = np; cfg_terminal = nt; cfg_repeat = nr;
      end else begin
         cfg_valid = 1'b0;
         cfg_preset = 4'($urandom); cfg_terminal = 4'($urandom); cfg_repeat = 4'($urandom);
      end
      for (int k = 1; k <= n + 1; k++) begin
         @(negedge clock);
         eload = (k <= n) && ((k - 1) % (d + 2) == 0);
         epass = (k <= n) ? 4'((k - 1) / (d + 2)) : r;
         exp_v = {eload, 1'b1, (k == n + 1), 1'b0, epass, p};
         act_v = {load, busy, done, cfg_ready, pass_cnt, data};
         nvec++;
         if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL seq p=%0d t=%0d r=%0d cyc=E0+%0d: {load,busy,done,ready,pass,data} got %h want %h",
                     p, t, r, k, act_v, exp_v);
         end
      end
   endtask

   task automatic start_cfg(input logic [3:0] p, t, r);
      @(negedge clock);
      cfg_valid = 1'b1; cfg_preset = p; cfg_terminal = t; cfg_repeat = r;
      @(posedge clock); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic abort_at(input logic [3:0] p, t, input logic [3:0] at);
      bit found = 0;
      start_cfg(p, t, 4'd0);
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (busy && !load && cnt == at) found = 1;
      end
      nvec++;
      if (!found) begin
         nerr++;
         $display("FAIL abort_wait: count never reached %0d want reached", at);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check_idle("abort_idle");
   endtask

   task automatic test_reset;
      #2;
      nvec++;
      if ({load, data, done, busy, pass_cnt, cfg_ready} !== {1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
         nerr++;
         $display("FAIL reset_state: got %b %h %b %b %h %b want 0 0 0 0 0 1",
                  load, data, done, busy, pass_cnt, cfg_ready);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_directed;
      run_cfg(4'd3,  4'd7, 4'd0, 0, 0, 0, 0, 0);
      run_cfg(4'd14, 4'd1, 4'd0, 0, 0, 0, 0, 0);
      run_cfg(4'd2,  4'd5, 4'd2, 0, 0, 0, 0, 0);
      run_cfg(4'd9,  4'd9, 4'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_abort;
      abort_at(4'd3, 4'd7, 4'd5);
      run_cfg(4'd0, 4'd1, 4'd0, 0, 0, 0, 0, 0);
      abort_at(4'd3, 4'd7, 4'd7);
      run_cfg(4'd5, 4'd8, 4'd1, 1, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back;
      run_cfg(4'd1, 4'd4, 4'd1, 0, 1, 4'd6, 4'd2, 4'd0);
      run_cfg(4'd6, 4'd2, 4'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid;
      bit found = 0;
      start_cfg(4'd2, 4'd5, 4'd2);
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (busy && !load && pass_cnt == 4'd1) found = 1;
      end
      nvec++;
      if (!found) begin
         nerr++;
         $display("FAIL reset_mid_wait: pass 1 RUN not reached want reached");
      end
      #2 reset = 1'b0;
      #1;
      nvec++;
      if ({load, busy, pass_cnt, done, data, cfg_ready} !== {1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1}) begin
         nerr++;
         $display("FAIL reset_mid: load/busy/pass/done/data/ready got %b %b %h %b %h %b want 0 0 0 0 0 1",
                  load, busy, pass_cnt, done, data, cfg_ready);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_random;
      for (int i = 0; i < 20; i++)
         run_cfg(4'($urandom), 4'($urandom), 4'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
      cfg_preset = 4'd0; cfg_terminal = 4'd0; cfg_repeat = 4'd0;
      test_reset;
      test_directed;
      test_abort;
      test_back_to_back;
      test_reset_mid;
      test_random;
      @(negedge clock);
      check_idle("final_idle");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/counter_load_controller.md
# counter_load_controller

Sequencing controller sitting directly upstream of the 4-bit loadable up-counter (`counter_4bit_load_up`). It accepts a configuration (preset, terminal, repeat) over a valid/ready handshake. It then drives the counter's `load`/`data` inputs to preload it, watches the returned `count` for the terminal value, and reloads for the requested number of passes. After the final pass it signals completion with a one-cycle pulse.

## Interface
- `WIDTH`, 4: counter/data width.
- `REP_W`, 4: width of the repeat/pass counter.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration valid.
- `cfg_ready`  out  1  controller idle and able to accept a configuration.
- `cfg_preset`  in  WIDTH  value loaded into the counter at the start of each pass.
- `cfg_terminal`  in  WIDTH  count value that ends a pass.
- `cfg_repeat`  in  REP_W  additional passes after the first (0 = single pass).
- `abort`  in  1  cancel the sequence in progress.
- `count`  in  WIDTH  counter output (free-running up, increments every cycle unless loaded).
- `load`  out  1  counter load strobe.
- `data`  out  WIDTH  counter load value.
- `busy`  out  1  sequence in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `pass_cnt`  out  REP_W  index of the current pass, starting at 0.

## Operation
- States: IDLE, LOAD, RUN, DONE. Outputs are decoded from the state register plus the latched config (Moore).
- **IDLE.** `cfg_ready`=1. On `cfg_valid & cfg_ready`: latch preset/terminal/repeat, clear `pass_cnt`, go to LOAD.
- **LOAD.** `load`=1 and `data`=latched preset for exactly one cycle, then go to RUN.
- **RUN.** Compare `count` with the latched terminal every cycle.
  - On a match with `pass_cnt == repeat`: go to DONE.
  - On a match otherwise: increment `pass_cnt` and go to LOAD.
- **DONE.** `done`=1 for one cycle, then go to IDLE.
- `data` holds the latched preset in all non-IDLE states and is 0 in IDLE.
- **Arithmetic.** Pass length d = (terminal − preset) mod 2^WIDTH, i.e. wrap-around through 15→0 is legal. preset == terminal gives d = 0.
- **Config changes.** `cfg_*` changes while busy are ignored; the source must hold `cfg_valid` until accepted.
- **abort.**
  - In LOAD/RUN/DONE: go to IDLE next edge, with no `done` and `load` deasserted.
  - abort wins over a simultaneous terminal match.
  - In IDLE, abort is ignored; a simultaneous `cfg_valid` is accepted.
- **Reset (async, reset = 0).**
  - State returns to IDLE immediately, including mid-sequence.
  - `load`=0, `data`=0, `done`=0, `busy`=0, `pass_cnt`=0.
  - `cfg_ready`=1 (it is state == IDLE).
  - Latched config is cleared to 0.

## Timing
- Handshake accepted at edge E0. LOAD occupies cycle E0+1, and the counter loads at the end of that cycle.
- `count` equals preset in cycle E0+2, the first RUN cycle.
- Match occurs in cycle E0+2+d. The next cycle is either LOAD (reload) or DONE.
- Per-pass period is d+2 cycles. `done` is high in cycle E0 + (repeat+1)(d+2) + 1.
- `cfg_ready` rises in the cycle after DONE. Back-to-back configs lose no further cycle.
- `count` is compared in RUN only; its value during LOAD/DONE is don't-care.

## Structure
- Shared package `counter_ctrl_pkg`:
  - state encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - default WIDTH/REP_W constants.
- No internal sub-module. Add an integration wrapper `counter_load_system` that instantiates this block and `counter_4bit_load_up` with `load`/`data`/`count` tied together and a shared `clock`/`reset`. Adapt reset polarity at the wrapper if the counter's reset differs.

## Test plan
- preset=3, terminal=7, repeat=0: `load`=1 for one cycle with `data`=3; `count` runs 3..7; `done` pulses in cycle E0+7; `busy` is low afterwards.
- preset=14, terminal=1, repeat=0 (wrap): `count` runs 14,15,0,1; `done` at E0+6.
- preset=2, terminal=5, repeat=2:
  - three `load` pulses at E0+1, E0+6, E0+11;
  - `pass_cnt` steps 0,1,2;
  - a single `done` at E0+16.
- preset=9, terminal=9, repeat=0: match in the first RUN cycle; `done` at E0+3.
- Abort:
  - assert `abort` when `count`=5 in the first test: no `done`, `cfg_ready` is 1 next cycle;
  - a new config (preset=0, terminal=1) is then accepted, with `done` at E0'+4.
- Drive `reset`=0 mid-RUN: `load`/`busy`/`pass_cnt` are 0 immediately (before the next edge); `cfg_valid` is held while busy and accepted only after returning to IDLE.
